// File: rtl/alu_sequencer_if.sv
// ALU sequencer control interface.
// The master side is the sequencer: it takes instructions, memory
// completion and ALU flags, and drives ALU, register-file, PC and memory
// controls. The slave side is the surrounding datapath.
interface alu_sequencer_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  alu_op;
  logic        alu_sub_en;
  logic        alu_sra_en;
  logic        alu_bus_en;
  logic        alu_addr_en;
  logic [1:0]  a_sel;
  logic [1:0]  b_sel;
  logic [31:0] imm;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        rf_we;
  logic        pc_we;
  logic        pc_clr_lsb;
  logic        mem_re;
  logic        mem_we;
  logic [2:0]  mem_size;
  logic        mem_ready;
  logic        alu_eq;
  logic        alu_lt;
  logic        alu_ltu;
  logic        alu_ge;
  logic        alu_geu;
  logic        done;
  logic        illegal;

  modport master (
    input  instr, instr_valid, mem_ready,
           alu_eq, alu_lt, alu_ltu, alu_ge, alu_geu,
    output instr_ready, alu_op, alu_sub_en, alu_sra_en, alu_bus_en, alu_addr_en,
           a_sel, b_sel, imm, rs1, rs2, rd, rf_we, pc_we, pc_clr_lsb,
           mem_re, mem_we, mem_size, done, illegal
  );

  modport slave (
    output instr, instr_valid, mem_ready,
           alu_eq, alu_lt, alu_ltu, alu_ge, alu_geu,
    input  instr_ready, alu_op, alu_sub_en, alu_sra_en, alu_bus_en, alu_addr_en,
           a_sel, b_sel, imm, rs1, rs2, rd, rf_we, pc_we, pc_clr_lsb,
           mem_re, mem_we, mem_size, done, illegal
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle RV32I control sequencer for the ALU datapath.
// Accepts one instruction in IDLE, decodes it into registered fields and
// then steps through a short per-class state sequence. Outputs depend only
// on the state and latched fields, except for MEM completion on mem_ready.
// All outputs are forced to 0 while rst is high.
module alu_sequencer #(
  parameter int RESET_IDLE = 1
) (
  input logic            clk,
  input logic            rst,
  alu_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, DECODE, EXEC, BR_CMP, BR_TGT, J_LINK, J_TGT, MEM, TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_OP, C_OP_IMM, C_LUI, C_AUIPC, C_BRANCH, C_JAL, C_JALR, C_LOAD, C_STORE, C_ILLEGAL
  } cls_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  // IDLE is the only supported reset state; any parameter value lands there.
  localparam state_t RESET_STATE = (RESET_IDLE == 1) ? IDLE : IDLE;

  state_t      state, state_next;
  logic [31:0] instr_q;
  cls_t        cls_q;
  logic [2:0]  funct3_q;
  logic        funct7_5_q;
  logic [31:0] imm_q;
  logic [4:0]  rs1_q, rs2_q, rd_q;
  logic        taken_q;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm, sh_imm;
  cls_t        dec_cls;
  logic [31:0] dec_imm;
  logic        branch_taken;

  assign opcode = instr_q[6:0];
  assign f3     = instr_q[14:12];
  assign f7     = instr_q[31:25];
  assign i_imm  = {{20{instr_q[31]}}, instr_q[31:20]};
  assign s_imm  = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign b_imm  = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign u_imm  = {instr_q[31:12], 12'b0};
  assign j_imm  = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
  assign sh_imm = {27'b0, instr_q[24:20]};

  // Classify the latched word, screen illegal encodings and pick its immediate.
  always_comb begin
    dec_cls = C_ILLEGAL;
    dec_imm = '0;
    case (opcode)
      OPC_OP: begin
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)))
          dec_cls = C_OP;
      end
      OPC_OP_IMM: begin
        if (f3 == 3'b001) begin
          dec_imm = sh_imm;
          if (f7 == 7'h00) dec_cls = C_OP_IMM;
        end else if (f3 == 3'b101) begin
          dec_imm = sh_imm;
          if (f7 == 7'h00 || f7 == 7'h20) dec_cls = C_OP_IMM;
        end else begin
          dec_imm = i_imm;
          dec_cls = C_OP_IMM;
        end
      end
      OPC_LUI: begin
        dec_imm = u_imm;
        dec_cls = C_LUI;
      end
      OPC_AUIPC: begin
        dec_imm = u_imm;
        dec_cls = C_AUIPC;
      end
      OPC_BRANCH: begin
        dec_imm = b_imm;
        if (f3 != 3'b010 && f3 != 3'b011) dec_cls = C_BRANCH;
      end
      OPC_JAL: begin
        dec_imm = j_imm;
        dec_cls = C_JAL;
      end
      OPC_JALR: begin
        dec_imm = i_imm;
        if (f3 == 3'b000) dec_cls = C_JALR;
      end
      OPC_LOAD: begin
        dec_imm = i_imm;
        if (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) dec_cls = C_LOAD;
      end
      OPC_STORE: begin
        dec_imm = s_imm;
        if (f3 <= 3'b010) dec_cls = C_STORE;
      end
      default: dec_cls = C_ILLEGAL;
    endcase
  end

  // Resolve the branch condition from the ALU flags for the latched funct3.
  always_comb begin
    branch_taken = 1'b0;
    case (funct3_q)
      3'b000:  branch_taken = bus.alu_eq;
      3'b001:  branch_taken = ~bus.alu_eq;
      3'b100:  branch_taken = bus.alu_lt;
      3'b101:  branch_taken = bus.alu_ge;
      3'b110:  branch_taken = bus.alu_ltu;
      3'b111:  branch_taken = bus.alu_geu;
      default: branch_taken = 1'b0;
    endcase
  end

  // State register plus the instruction, decoded-field and branch latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RESET_STATE;
      instr_q    <= '0;
      cls_q      <= C_ILLEGAL;
      funct3_q   <= '0;
      funct7_5_q <= 1'b0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      taken_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && bus.instr_valid) instr_q <= bus.instr;
      if (state == DECODE) begin
        cls_q      <= dec_cls;
        funct3_q   <= f3;
        funct7_5_q <= instr_q[30];
        imm_q      <= dec_imm;
        rs1_q      <= instr_q[19:15];
        rs2_q      <= instr_q[24:20];
        rd_q       <= instr_q[11:7];
      end
      if (state == BR_CMP) taken_q <= branch_taken;
    end
  end

  // Next-state selection by state, decoded class and memory completion.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (bus.instr_valid) state_next = DECODE;
      DECODE: begin
        case (dec_cls)
          C_OP, C_OP_IMM, C_LUI, C_AUIPC: state_next = EXEC;
          C_BRANCH:                       state_next = BR_CMP;
          C_JAL, C_JALR:                  state_next = J_LINK;
          C_LOAD, C_STORE:                state_next = MEM;
          default:                        state_next = TRAP;
        endcase
      end
      EXEC:   state_next = IDLE;
      BR_CMP: state_next = BR_TGT;
      BR_TGT: state_next = IDLE;
      J_LINK: state_next = J_TGT;
      J_TGT:  state_next = IDLE;
      MEM:    if (bus.mem_ready) state_next = IDLE;
      TRAP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control outputs per state; everything reads 0 while rst is high.
  always_comb begin
    bus.instr_ready = 1'b0;
    bus.alu_op      = 3'b000;
    bus.alu_sub_en  = 1'b0;
    bus.alu_sra_en  = 1'b0;
    bus.alu_bus_en  = 1'b0;
    bus.alu_addr_en = 1'b0;
    bus.a_sel       = 2'd0;
    bus.b_sel       = 2'd0;
    bus.imm         = '0;
    bus.rs1         = '0;
    bus.rs2         = '0;
    bus.rd          = '0;
    bus.rf_we       = 1'b0;
    bus.pc_we       = 1'b0;
    bus.pc_clr_lsb  = 1'b0;
    bus.mem_re      = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_size    = 3'b000;
    bus.done        = 1'b0;
    bus.illegal     = 1'b0;
    if (!rst) begin
      bus.imm = imm_q;
      bus.rs1 = rs1_q;
      bus.rs2 = rs2_q;
      bus.rd  = rd_q;
      case (state)
        IDLE: bus.instr_ready = 1'b1;
        EXEC: begin
          bus.alu_bus_en = 1'b1;
          bus.rf_we      = (rd_q != 5'd0);
          bus.done       = 1'b1;
          case (cls_q)
            C_OP: begin
              bus.alu_op     = funct3_q;
              bus.alu_sub_en = funct7_5_q & (funct3_q == 3'b000);
              bus.alu_sra_en = funct7_5_q & (funct3_q == 3'b101);
            end
            C_OP_IMM: begin
              bus.b_sel      = 2'd1;
              bus.alu_op     = funct3_q;
              bus.alu_sra_en = funct7_5_q & (funct3_q == 3'b101);
            end
            C_LUI: begin
              bus.a_sel = 2'd2;
              bus.b_sel = 2'd1;
            end
            C_AUIPC: begin
              bus.a_sel = 2'd1;
              bus.b_sel = 2'd1;
            end
            default: bus.alu_op = 3'b000;
          endcase
        end
        BR_CMP: begin
          bus.a_sel = 2'd0;
          bus.b_sel = 2'd0;
        end
        BR_TGT: begin
          bus.a_sel       = 2'd1;
          bus.b_sel       = 2'd1;
          bus.alu_addr_en = taken_q;
          bus.pc_we       = taken_q;
          bus.done        = 1'b1;
        end
        J_LINK: begin
          bus.a_sel      = 2'd1;
          bus.b_sel      = 2'd2;
          bus.alu_bus_en = 1'b1;
          bus.rf_we      = (rd_q != 5'd0);
        end
        J_TGT: begin
          bus.a_sel       = (cls_q == C_JAL) ? 2'd1 : 2'd0;
          bus.b_sel       = 2'd1;
          bus.alu_addr_en = 1'b1;
          bus.pc_we       = 1'b1;
          bus.pc_clr_lsb  = (cls_q == C_JALR);
          bus.done        = 1'b1;
        end
        MEM: begin
          bus.b_sel       = 2'd1;
          bus.alu_addr_en = 1'b1;
          bus.mem_size    = funct3_q;
          bus.mem_re      = (cls_q == C_LOAD);
          bus.mem_we      = (cls_q == C_STORE);
          if (bus.mem_ready) begin
            bus.done  = 1'b1;
            bus.rf_we = (cls_q == C_LOAD) && (rd_q != 5'd0);
          end
        end
        TRAP: begin
          bus.illegal = 1'b1;
          bus.done    = 1'b1;
        end
        default: bus.instr_ready = 1'b0;
      endcase
    end
  end

endmodule
